// File: rtl/fbuf_sched_if.sv
// Writer/reader handshake bundle between the frame-buffer scheduler and the
// stream's write/read DMA engines.
interface fbuf_sched_if #(
    parameter int C_IDX_BITS       = 2,
    parameter int C_BUF_ADDR_WIDTH = 32
);
    logic                        wr_req;
    logic                        wr_done;
    logic                        wr_ack;
    logic [C_IDX_BITS-1:0]       wr_idx;
    logic [C_BUF_ADDR_WIDTH-1:0] wr_addr;
    logic                        rd_req;
    logic                        rd_ack;
    logic [C_IDX_BITS-1:0]       rd_idx;
    logic [C_BUF_ADDR_WIDTH-1:0] rd_addr;
    logic                        rd_new;

    modport master (
        output wr_req, wr_done, rd_req,
        input  wr_ack, wr_idx, wr_addr, rd_ack, rd_idx, rd_addr, rd_new
    );

    modport slave (
        input  wr_req, wr_done, rd_req,
        output wr_ack, wr_idx, wr_addr, rd_ack, rd_idx, rd_addr, rd_new
    );
endinterface

// File: rtl/fbuf_sched.sv
// Buffer-ring scheduler: grants free buffers to the capture writer, publishes the
// latest completed frame and hands it to the display reader without overlap.
module fbuf_sched #(
    parameter int C_BUF_NUM        = 4,
    parameter int C_IDX_BITS       = 2,
    parameter int C_BUF_ADDR_WIDTH = 32,
    parameter int C_CNT_BITS       = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        soft_resetn,
    input  logic [C_BUF_ADDR_WIDTH-1:0] buf0_addr,
    input  logic [C_BUF_ADDR_WIDTH-1:0] buf1_addr,
    input  logic [C_BUF_ADDR_WIDTH-1:0] buf2_addr,
    input  logic [C_BUF_ADDR_WIDTH-1:0] buf3_addr,
    fbuf_sched_if.slave                 bus,
    output logic [C_CNT_BITS-1:0]       frame_cnt,
    output logic [C_CNT_BITS-1:0]       drop_cnt
);

    localparam logic [C_IDX_BITS-1:0] IDX_LAST = C_IDX_BITS'(C_BUF_NUM - 1);

    logic                  w_busy;
    logic                  latest_valid;
    logic [C_IDX_BITS-1:0] latest_idx;

    // State after applying wr_done, then rd_req, then wr_req in that order.
    logic                  busy_1;
    logic                  lat_valid_1;
    logic [C_IDX_BITS-1:0] lat_idx_1;
    logic                  frame_inc;
    logic [C_IDX_BITS-1:0] rd_idx_2;
    logic                  rd_new_2;
    logic [C_IDX_BITS-1:0] cand;
    logic [C_IDX_BITS-1:0] pick;
    logic                  found;

    function automatic logic [C_BUF_ADDR_WIDTH-1:0] addr_of(input logic [C_IDX_BITS-1:0] idx);
        case (idx)
            C_IDX_BITS'(0): addr_of = buf0_addr;
            C_IDX_BITS'(1): addr_of = buf1_addr;
            C_IDX_BITS'(2): addr_of = buf2_addr;
            default:        addr_of = buf3_addr;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        busy_1      = w_busy;
        lat_valid_1 = latest_valid;
        lat_idx_1   = latest_idx;
        frame_inc   = 1'b0;
        if (bus.wr_done && w_busy) begin
            lat_idx_1   = bus.wr_idx;
            lat_valid_1 = 1'b1;
            busy_1      = 1'b0;
            frame_inc   = 1'b1;
        end

        rd_idx_2 = bus.rd_idx;
        rd_new_2 = 1'b0;
        if (bus.rd_req && lat_valid_1 && (lat_idx_1 != bus.rd_idx)) begin
            rd_idx_2 = lat_idx_1;
            rd_new_2 = 1'b1;
        end

        // Round-robin from wr_idx+1; the current (possibly abandoned) buffer comes last.
        cand  = bus.wr_idx;
        pick  = bus.wr_idx;
        found = 1'b0;
        for (int k = 0; k < C_BUF_NUM; k++) begin
            cand = (cand == IDX_LAST) ? '0 : cand + 1'b1;
            if (!found && (cand != rd_idx_2) && !(lat_valid_1 && (cand == lat_idx_1))) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn || !soft_resetn) begin
            w_busy       <= 1'b0;
            latest_valid <= 1'b0;
            latest_idx   <= '0;
            frame_cnt    <= '0;
            drop_cnt     <= '0;
            bus.wr_ack   <= 1'b0;
            bus.wr_idx   <= '0;
            bus.wr_addr  <= '0;
            bus.rd_ack   <= 1'b0;
            bus.rd_idx   <= '0;
            bus.rd_addr  <= '0;
            bus.rd_new   <= 1'b0;
        end else begin
            w_busy       <= busy_1;
            latest_valid <= lat_valid_1;
            latest_idx   <= lat_idx_1;
            if (frame_inc) begin
                frame_cnt <= frame_cnt + 1'b1;
            end

            bus.rd_ack <= bus.rd_req;
            if (bus.rd_req) begin
                bus.rd_idx  <= rd_idx_2;
                bus.rd_addr <= addr_of(rd_idx_2);
                bus.rd_new  <= rd_new_2;
            end

            bus.wr_ack <= bus.wr_req;
            if (bus.wr_req) begin
                bus.wr_idx  <= pick;
                bus.wr_addr <= addr_of(pick);
                w_busy      <= 1'b1;
                // A grant while still busy abandons the previous frame.
                if (busy_1 && (drop_cnt != '1)) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fbuf_sched.sv
// Directed bench for fbuf_sched: a 4-buffer instance and a 3-buffer instance
// with 8-bit counters for the saturation boundary.
module tb_fbuf_sched;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic soft_resetn = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    localparam logic [31:0] A0 = 32'h1000_0000, A1 = 32'h1100_0000, A2 = 32'h1200_0000, A3 = 32'h1300_0000;
    localparam logic [31:0] B0 = 32'h2000_0000, B1 = 32'h2100_0000, B2 = 32'h2200_0000, B3 = 32'hDEAD_BEEF;

    fbuf_sched_if #(.C_IDX_BITS(2), .C_BUF_ADDR_WIDTH(32)) ia ();
    fbuf_sched_if #(.C_IDX_BITS(2), .C_BUF_ADDR_WIDTH(32)) ib ();
    logic [15:0] frame_a, drop_a;
    logic [7:0]  frame_b, drop_b;

    fbuf_sched #(.C_BUF_NUM(4), .C_IDX_BITS(2), .C_BUF_ADDR_WIDTH(32), .C_CNT_BITS(16)) dut_a (
        .clk(clk), .resetn(resetn), .soft_resetn(soft_resetn),
        .buf0_addr(A0), .buf1_addr(A1), .buf2_addr(A2), .buf3_addr(A3),
        .bus(ia), .frame_cnt(frame_a), .drop_cnt(drop_a)
    );

    fbuf_sched #(.C_BUF_NUM(3), .C_IDX_BITS(2), .C_BUF_ADDR_WIDTH(32), .C_CNT_BITS(8)) dut_b (
        .clk(clk), .resetn(resetn), .soft_resetn(soft_resetn),
        .buf0_addr(B0), .buf1_addr(B1), .buf2_addr(B2), .buf3_addr(B3),
        .bus(ib), .frame_cnt(frame_b), .drop_cnt(drop_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of requests; on return the outputs of that edge are visible.
    task automatic step_a(input logic wq, input logic wd, input logic rq);
        ia.wr_req = wq; ia.wr_done = wd; ia.rd_req = rq;
        tick();
        ia.wr_req = 1'b0; ia.wr_done = 1'b0; ia.rd_req = 1'b0;
    endtask

    task automatic step_b(input logic wq, input logic wd, input logic rq);
        ib.wr_req = wq; ib.wr_done = wd; ib.rd_req = rq;
        tick();
        ib.wr_req = 1'b0; ib.wr_done = 1'b0; ib.rd_req = 1'b0;
    endtask

    task automatic hard_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        ia.wr_req = 0; ia.wr_done = 0; ia.rd_req = 0;
        ib.wr_req = 0; ib.wr_done = 0; ib.rd_req = 0;
        tick();
        tick();
        checks++; if ({ia.wr_ack, ia.rd_ack, ia.rd_new} !== 3'b000) begin errors++; $display("FAIL reset_acks got=%b exp=000", {ia.wr_ack, ia.rd_ack, ia.rd_new}); end
        checks++; if ({ia.wr_idx, ia.rd_idx} !== 4'd0) begin errors++; $display("FAIL reset_idx got=%h exp=0", {ia.wr_idx, ia.rd_idx}); end
        checks++; if ({ia.wr_addr, ia.rd_addr} !== 64'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", {ia.wr_addr, ia.rd_addr}); end
        checks++; if ({frame_a, drop_a} !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", {frame_a, drop_a}); end
        // Requests during reset are lost.
        step_a(1, 0, 1);
        checks++; if ({ia.wr_ack, ia.rd_ack} !== 2'b00) begin errors++; $display("FAIL reset_req_in_reset got=%b exp=00", {ia.wr_ack, ia.rd_ack}); end
        resetn = 1'b1;
        tick();
        checks++; if ({ia.wr_ack, ia.rd_ack} !== 2'b00) begin errors++; $display("FAIL reset_req_lost got=%b exp=00", {ia.wr_ack, ia.rd_ack}); end
    endtask

    task automatic test_first_read();
        step_a(0, 0, 1);
        checks++; if (ia.rd_ack !== 1'b1) begin errors++; $display("FAIL first_rd_ack got=%b exp=1", ia.rd_ack); end
        checks++; if (ia.rd_idx !== 2'd0 || ia.rd_new !== 1'b0) begin errors++; $display("FAIL first_rd_idx_new got=%0d/%b exp=0/0", ia.rd_idx, ia.rd_new); end
        checks++; if (ia.rd_addr !== A0) begin errors++; $display("FAIL first_rd_addr got=%h exp=%h", ia.rd_addr, A0); end
        step_a(1, 0, 0);
        checks++; if (ia.wr_ack !== 1'b1 || ia.rd_ack !== 1'b0) begin errors++; $display("FAIL first_wr_ack got=%b/%b exp=1/0", ia.wr_ack, ia.rd_ack); end
        checks++; if (ia.wr_idx !== 2'd1 || ia.wr_addr !== A1) begin errors++; $display("FAIL first_wr_idx got=%0d/%h exp=1/%h", ia.wr_idx, ia.wr_addr, A1); end
        tick();
        checks++; if (ia.wr_ack !== 1'b0 || ia.wr_idx !== 2'd1) begin errors++; $display("FAIL first_wr_hold got=%b/%0d exp=0/1", ia.wr_ack, ia.wr_idx); end
    endtask

    task automatic test_ping_pong();
        hard_reset();
        step_a(1, 0, 0);
        checks++; if (ia.wr_idx !== 2'd1) begin errors++; $display("FAIL pp_wr1 got=%0d exp=1", ia.wr_idx); end
        step_a(0, 1, 0);
        step_a(0, 0, 1);
        checks++; if (ia.rd_idx !== 2'd1 || ia.rd_new !== 1'b1 || ia.rd_addr !== A1) begin errors++; $display("FAIL pp_rd1 got=%0d/%b/%h exp=1/1/%h", ia.rd_idx, ia.rd_new, ia.rd_addr, A1); end
        step_a(1, 0, 0);
        checks++; if (ia.wr_idx !== 2'd2 || ia.wr_addr !== A2) begin errors++; $display("FAIL pp_wr2 got=%0d/%h exp=2/%h", ia.wr_idx, ia.wr_addr, A2); end
        step_a(0, 1, 0);
        step_a(0, 0, 1);
        checks++; if (ia.rd_idx !== 2'd2 || ia.rd_new !== 1'b1) begin errors++; $display("FAIL pp_rd2 got=%0d/%b exp=2/1", ia.rd_idx, ia.rd_new); end
        checks++; if (frame_a !== 16'd2) begin errors++; $display("FAIL pp_frame_cnt got=%0d exp=2", frame_a); end
        // No newer frame: repeat.
        step_a(0, 0, 1);
        checks++; if (ia.rd_idx !== 2'd2 || ia.rd_new !== 1'b0) begin errors++; $display("FAIL pp_rd_repeat got=%0d/%b exp=2/0", ia.rd_idx, ia.rd_new); end
    endtask

    task automatic test_reader_stall();
        int exp_seq[6] = '{1, 2, 3, 1, 2, 3};
        hard_reset();
        for (int i = 0; i < 6; i++) begin
            step_a(1, 0, 0);
            checks++; if (ia.wr_idx !== 2'(exp_seq[i])) begin errors++; $display("FAIL stall_wr_%0d got=%0d exp=%0d", i, ia.wr_idx, exp_seq[i]); end
            step_a(0, 1, 0);
        end
        checks++; if (frame_a !== 16'd6) begin errors++; $display("FAIL stall_frame_cnt got=%0d exp=6", frame_a); end
        step_a(0, 0, 1);
        checks++; if (ia.rd_idx !== 2'd3 || ia.rd_new !== 1'b1 || ia.rd_addr !== A3) begin errors++; $display("FAIL stall_latest got=%0d/%b/%h exp=3/1/%h", ia.rd_idx, ia.rd_new, ia.rd_addr, A3); end
    endtask

    task automatic test_same_cycle();
        hard_reset();
        step_a(1, 0, 0);
        step_a(0, 1, 0);
        step_a(0, 0, 1);
        step_a(1, 0, 0);
        checks++; if (ia.wr_idx !== 2'd2 || ia.rd_idx !== 2'd1) begin errors++; $display("FAIL same_setup got=%0d/%0d exp=2/1", ia.wr_idx, ia.rd_idx); end
        step_a(1, 1, 1);
        checks++; if (ia.wr_ack !== 1'b1 || ia.rd_ack !== 1'b1) begin errors++; $display("FAIL same_acks got=%b/%b exp=1/1", ia.wr_ack, ia.rd_ack); end
        checks++; if (ia.rd_idx !== 2'd2 || ia.rd_new !== 1'b1) begin errors++; $display("FAIL same_rd got=%0d/%b exp=2/1", ia.rd_idx, ia.rd_new); end
        checks++; if (ia.wr_idx !== 2'd3 || ia.wr_addr !== A3) begin errors++; $display("FAIL same_wr got=%0d/%h exp=3/%h", ia.wr_idx, ia.wr_addr, A3); end
        checks++; if (frame_a !== 16'd2 || drop_a !== 16'd0) begin errors++; $display("FAIL same_cnts got=%0d/%0d exp=2/0", frame_a, drop_a); end
    endtask

    task automatic test_drop();
        hard_reset();
        step_a(1, 0, 0);
        step_a(1, 0, 0);
        checks++; if (ia.wr_idx !== 2'd2 || drop_a !== 16'd1) begin errors++; $display("FAIL drop_first got=%0d/%0d exp=2/1", ia.wr_idx, drop_a); end
        step_a(1, 0, 0);
        step_a(1, 0, 0);
        checks++; if (ia.wr_idx !== 2'd1 || drop_a !== 16'd3) begin errors++; $display("FAIL drop_wrap got=%0d/%0d exp=1/3", ia.wr_idx, drop_a); end
        checks++; if (frame_a !== 16'd0) begin errors++; $display("FAIL drop_frame_cnt got=%0d exp=0", frame_a); end
        // Completion in the same cycle as the next request is not a drop.
        step_a(1, 1, 0);
        checks++; if (ia.wr_idx !== 2'd2 || drop_a !== 16'd3 || frame_a !== 16'd1) begin errors++; $display("FAIL drop_done_same got=%0d/%0d/%0d exp=2/3/1", ia.wr_idx, drop_a, frame_a); end
        step_a(0, 1, 0);
        step_a(0, 1, 0);
        checks++; if (frame_a !== 16'd2) begin errors++; $display("FAIL drop_idle_done got=%0d exp=2", frame_a); end
    endtask

    task automatic test_soft_reset();
        hard_reset();
        step_a(1, 0, 0);
        step_a(0, 1, 0);
        step_a(1, 0, 0);
        checks++; if (ia.wr_idx !== 2'd2) begin errors++; $display("FAIL sr_setup got=%0d exp=2", ia.wr_idx); end
        soft_resetn = 1'b0;
        tick();
        soft_resetn = 1'b1;
        checks++; if ({ia.wr_idx, ia.rd_idx, ia.wr_ack, ia.rd_ack, ia.rd_new} !== 7'd0 || {ia.wr_addr, ia.rd_addr} !== 64'd0) begin errors++; $display("FAIL sr_outputs got=%0d/%0d/%h exp=0/0/0", ia.wr_idx, ia.rd_idx, ia.wr_addr); end
        checks++; if ({frame_a, drop_a} !== 32'd0) begin errors++; $display("FAIL sr_cnts got=%h exp=0", {frame_a, drop_a}); end
        step_a(0, 0, 1);
        checks++; if (ia.rd_idx !== 2'd0 || ia.rd_new !== 1'b0) begin errors++; $display("FAIL sr_rd got=%0d/%b exp=0/0", ia.rd_idx, ia.rd_new); end
        step_a(1, 0, 0);
        checks++; if (ia.wr_idx !== 2'd1 || drop_a !== 16'd0) begin errors++; $display("FAIL sr_wr got=%0d/%0d exp=1/0", ia.wr_idx, drop_a); end
    endtask

    task automatic test_three_buf();
        int  exp_seq[4] = '{1, 2, 1, 2};
        logic saw3 = 1'b0;
        hard_reset();
        for (int i = 0; i < 4; i++) begin
            step_b(1, 0, 0);
            checks++; if (ib.wr_idx !== 2'(exp_seq[i])) begin errors++; $display("FAIL three_wr_%0d got=%0d exp=%0d", i, ib.wr_idx, exp_seq[i]); end
            step_b(0, 1, 0);
        end
        step_b(0, 0, 1);
        checks++; if (ib.rd_idx !== 2'd2 || ib.rd_new !== 1'b1 || ib.rd_addr !== B2) begin errors++; $display("FAIL three_rd got=%0d/%b/%h exp=2/1/%h", ib.rd_idx, ib.rd_new, ib.rd_addr, B2); end
        step_b(1, 0, 0);
        checks++; if (ib.wr_idx !== 2'd0 || ib.wr_addr !== B0) begin errors++; $display("FAIL three_wrap got=%0d/%h exp=0/%h", ib.wr_idx, ib.wr_addr, B0); end
        step_b(1, 1, 0);
        checks++; if (ib.wr_idx !== 2'd1 || frame_b !== 8'd5) begin errors++; $display("FAIL three_next got=%0d/%0d exp=1/5", ib.wr_idx, frame_b); end
        soft_resetn = 1'b0;
        tick();
        soft_resetn = 1'b1;
        checks++; if ({ib.wr_idx, ib.rd_idx, frame_b, drop_b} !== 20'd0) begin errors++; $display("FAIL three_sr got=%h exp=0", {ib.wr_idx, ib.rd_idx, frame_b, drop_b}); end
        step_b(0, 0, 1);
        step_b(1, 0, 0);
        checks++; if (ib.rd_new !== 1'b0 || ib.wr_idx !== 2'd1) begin errors++; $display("FAIL three_sr_next got=%b/%0d exp=0/1", ib.rd_new, ib.wr_idx); end
        // Continuous requests with no completion: every grant abandons the previous frame.
        ib.wr_req = 1'b1;
        for (int i = 0; i < 254; i++) begin
            tick();
            if (ib.wr_idx == 2'd3) saw3 = 1'b1;
        end
        checks++; if (drop_b !== 8'hFE) begin errors++; $display("FAIL three_drop_fe got=%h exp=fe", drop_b); end
        tick();
        checks++; if (drop_b !== 8'hFF) begin errors++; $display("FAIL three_drop_ff got=%h exp=ff", drop_b); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ib.wr_idx == 2'd3) saw3 = 1'b1;
        end
        ib.wr_req = 1'b0;
        checks++; if (drop_b !== 8'hFF || frame_b !== 8'd0) begin errors++; $display("FAIL three_drop_sat got=%h/%0d exp=ff/0", drop_b, frame_b); end
        checks++; if (saw3 !== 1'b0) begin errors++; $display("FAIL three_idx3 got=%b exp=0", saw3); end
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_ping_pong();
        test_reader_stall();
        test_same_cycle();
        test_drop();
        test_soft_reset();
        test_three_buf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fbuf_sched.md
Name: fbuf_sched

Overview:
Frame-buffer scheduler for one capture stream's DDR buffer ring (the cmos buffer set). It hands a free buffer to the capture writer at each frame start, publishes the most recently completed frame, and hands that frame to the display reader. Writer and reader never touch the same buffer. It sits between the fsctl buffer-address outputs and the stream's write/read DMA engines, in the DMA clock domain.

Parameters:
C_BUF_NUM, 4, number of buffers in the ring; legal values are 3 or 4
C_IDX_BITS, 2, width of a buffer index
C_BUF_ADDR_WIDTH, 32, width of a buffer base address
C_CNT_BITS, 16, width of the status counters

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
soft_resetn  in  1  synchronous active-low clear, same effect as resetn
buf0_addr..buf3_addr  in  C_BUF_ADDR_WIDTH each  base addresses; buf3_addr ignored when C_BUF_NUM=3
wr_req  in  1  writer frame-start request, one-cycle pulse
wr_done  in  1  writer frame-complete pulse
wr_ack  out  1  one-cycle grant pulse to the writer
wr_idx  out  C_IDX_BITS  buffer granted to the writer
wr_addr  out  C_BUF_ADDR_WIDTH  base address of wr_idx
rd_req  in  1  reader frame-start request, one-cycle pulse
rd_ack  out  1  one-cycle grant pulse to the reader
rd_idx  out  C_IDX_BITS  buffer granted to the reader
rd_addr  out  C_BUF_ADDR_WIDTH  base address of rd_idx
rd_new  out  1  qualifies rd_ack: 1 = fresh frame, 0 = repeat of the previous frame
frame_cnt  out  C_CNT_BITS  completed frames, wraps
drop_cnt  out  C_CNT_BITS  abandoned writer frames, saturates at all-ones

Behaviour:
- Internal state: w_busy, latest_idx, latest_valid.
- Reset or soft_resetn=0 sets every output and internal register to 0: wr_idx=0, rd_idx=0, w_busy=0, latest_valid=0, latest_idx=0, and both counters 0.
- All outputs are registered. An ack pulses exactly 1 cycle after its req. Index, address and rd_new become valid in the same cycle as the ack and hold until the next ack.
- Same-cycle events are applied in a fixed order:
  - 1: wr_done
  - 2: rd_req
  - 3: wr_req
  - Each later step sees the updated state from the earlier steps.
- wr_done:
  - If w_busy: latest_idx<=wr_idx, latest_valid<=1, w_busy<=0, frame_cnt+1.
  - If not w_busy: ignored, no counter change.
- rd_req:
  - If latest_valid and latest_idx!=rd_idx: rd_idx<=latest_idx, rd_new=1.
  - Otherwise rd_idx is unchanged and rd_new=0 (repeat frame). This includes the case before the first completed frame, where rd_idx=0.
  - The reader keeps its buffer until its next rd_req.
- wr_req allocation:
  - Excluded buffers: the post-step-2 rd_idx, and latest_idx when latest_valid=1.
  - Search round-robin from (wr_idx+1) mod C_BUF_NUM and take the first non-excluded index.
  - With C_BUF_NUM>=3 a candidate always exists.
  - Then w_busy<=1.
- wr_req while w_busy=1 (no wr_done since the last grant):
  - The previous frame is abandoned and drop_cnt increments, saturating.
  - The abandoned buffer is not excluded, so it is eligible for the new grant.
- Wrap-around: the index search and frame_cnt wrap modulo their range; drop_cnt does not wrap.
- Requests arriving while reset is asserted are lost; no ack is produced afterwards.
- Reset mid-frame: the next ack after release follows the rules above from the reset state.
- Address mux: wr_addr/rd_addr = buf[idx]_addr. With C_BUF_NUM=3, index 3 is never produced.

Test Plan:
- Reset, then rd_req before any wr_done -> rd_ack 1 cycle later, rd_idx=0, rd_new=0. Then wr_req -> wr_ack, wr_idx=1 (0 excluded as read buffer).
- Sequence wr_req, wr_done, rd_req, wr_req, wr_done, rd_req (C_BUF_NUM=4) -> wr_idx 1, rd_idx 1 with rd_new=1, wr_idx 2, rd_idx 2 with rd_new=1; frame_cnt=2.
- Reader stalls (no rd_req) while writer runs 6 frames from reset -> wr_idx sequence 1,2,3,1,2,3 never equals rd_idx=0; frame_cnt=6; latest_idx=3.
- Same-cycle wr_done+rd_req+wr_req with wr_idx=2, rd_idx=1 -> rd_idx=2 with rd_new=1; wr_idx=3 (1 was free but search starts at 3); frame_cnt+1.
- Two wr_req with no wr_done between, repeated 0x10000 times -> drop_cnt saturates at 0xFFFF; frame_cnt unchanged.
- soft_resetn pulsed low mid-frame with wr_idx=2, latest_valid=1 -> all outputs 0. Next rd_req gives rd_new=0; next wr_req gives wr_idx=1. Repeat with C_BUF_NUM=3 -> idx 3 never seen.
